txd_scheduler: RTL
==================

// Module: txd_scheduler
// PURPOSE
//  Arbitrates the single UART TXD byte stream between two requesters:
//  - command-reply bytes (ID/metadata) from ctrl
//  - sample readout words from sram_interface
//  Sample words are serialised LSB-byte-first. Bytes whose tkeep bit is clear
//  (disabled channel groups) are skipped. Sits between ctrl/sram_interface and uart.
// PARAMETERS
//  MDW  32  sample memory word width, bits; multiple of 8
//  KW   MDW/8  tkeep width (derived; do not override)
//  CW   24  width of sent-sample-byte counter
// PORTS
//  clk             in   1    system clock
//  rst             in   1    reset, asynchronous, active-high
//  soft_reset      in   1    synchronous clear from ctrl
//  rep_tvalid      in   1    reply byte valid
//  rep_tdata       in   8    reply byte
//  rep_tlast       in   1    last byte of reply packet
//  rep_tready      out  1    reply byte accepted
//  mem_tvalid      in   1    sample word valid
//  mem_tdata       in   MDW  sample word
//  mem_tkeep       in   KW   byte enables of sample word
//  mem_tlast       in   1    last word of readout
//  mem_tready      out  1    sample word accepted
//  str_txd_tvalid  out  1    byte to UART valid
//  str_txd_tdata   out  8    byte to UART
//  str_txd_tready  in   1    UART accepts byte
//  busy            out  1    state != IDLE or output byte pending
//  mem_bytes       out  CW   sample bytes sent since reset/soft_reset; wraps
// BEHAVIOUR
//  Reset (rst, or soft_reset sampled high):
//  - all outputs 0, state IDLE, word buffer empty (kbuf=0), last_ld=0, mem_bytes=0
//  - soft_reset drops any pending output byte immediately (uart drains same cycle)
//  Output register:
//  - one byte (obuf, ovld); free = !ovld | str_txd_tready
//  - tdata held stable while tvalid & !tready
//  - one cycle from accept/extract to str_txd_tvalid
//  States: IDLE, REP, MEM
//  - IDLE: rep_tvalid -> REP; else mem_tvalid -> MEM. Reply wins if both valid.
//    No transfer occurs in the decision cycle.
//  - REP: rep_tready = free; byte loaded to obuf on rep handshake.
//    Handshake with rep_tlast=1 -> IDLE. Packet is never interleaved.
//  - MEM: mem_tready = (kbuf==0) & !last_ld. On handshake: wbuf<=tdata,
//    kbuf<=tkeep, last_ld<=tlast. When kbuf!=0 & free: i = lowest set bit of kbuf,
//    obuf<=wbuf[8i+:8], clear kbuf[i], mem_bytes++.
//    kbuf==0 & last_ld -> IDLE, last_ld<=0.
//  - Reply arriving during MEM waits until readout completes (no pre-emption).
//  Boundaries:
//  - word with tkeep=0 is accepted and produces no bytes
//  - word with tkeep=0 and tlast=1 ends MEM
//  - str_txd_tready low indefinitely: all inputs stall, no data loss
//  - mem_bytes wraps 2^CW-1 -> 0
//  - rst mid-packet: source must restart its packet
//  Throughput:
//  - reply: 1 byte/cycle when tready is held high
//  - sample: n bytes for n set keep bits, plus 1 bubble cycle per word
// TESTING
//  1 rep bytes 0x31,0x41,0x4C,0x53(tlast), tready=1
//    -> TXD "1ALS" in order, one per cycle; back to IDLE.
//  2 mem word 0x44332211 keep=4'b1111 tlast=1
//    -> TXD 11,22,33,44; mem_bytes=4.
//  3 mem words keep=4'b0101, then 4'b0000, then 4'b1000 (tlast)
//    -> bytes 0 and 2 of word 0, then byte 3 of word 2; mem_bytes=3.
//  4 rep_tvalid and mem_tvalid rise in the same cycle
//    -> whole reply first, then sample stream.
//    Reply arriving mid-readout -> emitted only after the mem tlast word's last byte.
//  5 str_txd_tready random 30% duty
//    -> byte sequence identical to tready=1 case; tdata stable during stalls.
//  6 soft_reset mid-MEM after 2 bytes
//    -> next cycle tvalid=0, mem_tready=0, busy=0, mem_bytes=0.
//    Fresh reply is then served normally.

Source files
------------

// File: rtl/txd_scheduler.sv
// Merges command-reply bytes and sample readout words onto one UART byte stream.
// Samples leave LSB byte first. Bytes whose keep bit is clear are skipped. A started reply or readout is never interleaved.
module txd_scheduler #(
  parameter int MDW = 32,
  parameter int CW  = 24,
  localparam int KW = MDW / 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           soft_reset,
  input  logic           rep_tvalid,
  input  logic [7:0]     rep_tdata,
  input  logic           rep_tlast,
  output logic           rep_tready,
  input  logic           mem_tvalid,
  input  logic [MDW-1:0] mem_tdata,
  input  logic [KW-1:0]  mem_tkeep,
  input  logic           mem_tlast,
  output logic           mem_tready,
  output logic           str_txd_tvalid,
  output logic [7:0]     str_txd_tdata,
  input  logic           str_txd_tready,
  output logic           busy,
  output logic [CW-1:0]  mem_bytes
);

  typedef enum logic [1:0] {S_IDLE, S_REP, S_MEM} state_t;

  state_t         state_q, state_d;
  logic [7:0]     obuf_q, obuf_d;
  logic           ovld_q, ovld_d;
  logic [MDW-1:0] wbuf_q, wbuf_d;
  logic [KW-1:0]  kbuf_q, kbuf_d;
  logic           last_ld_q, last_ld_d;
  logic [CW-1:0]  mb_q, mb_d;

  logic           free;
  logic           sel_found;
  logic [7:0]     sel_byte;
  logic [KW-1:0]  sel_mask;

  assign free = !ovld_q || str_txd_tready;

  // Lowest enabled byte still waiting in the word buffer.
  always_comb begin
    sel_found = 1'b0;
    sel_byte  = '0;
    sel_mask  = '0;
    for (int i = 0; i < KW; i++) begin
      if (kbuf_q[i] && !sel_found) begin
        sel_found   = 1'b1;
        sel_byte    = wbuf_q[8*i +: 8];
        sel_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    obuf_d     = obuf_q;
    ovld_d     = ovld_q;
    wbuf_d     = wbuf_q;
    kbuf_d     = kbuf_q;
    last_ld_d  = last_ld_q;
    mb_d       = mb_q;
    rep_tready = 1'b0;
    mem_tready = 1'b0;

    if (str_txd_tready) begin
      ovld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rep_tvalid) begin
          state_d = S_REP;
        end else if (mem_tvalid) begin
          state_d = S_MEM;
        end
      end
      S_REP: begin
        rep_tready = free;
        if (rep_tvalid && free) begin
          obuf_d = rep_tdata;
          ovld_d = 1'b1;
          if (rep_tlast) begin
            state_d = S_IDLE;
          end
        end
      end
      S_MEM: begin
        // A new word is only taken once the previous one is fully drained.
        mem_tready = (kbuf_q == '0) && !last_ld_q;
        if (mem_tvalid && mem_tready) begin
          wbuf_d    = mem_tdata;
          kbuf_d    = mem_tkeep;
          last_ld_d = mem_tlast;
        end else if (sel_found && free) begin
          obuf_d = sel_byte;
          ovld_d = 1'b1;
          kbuf_d = kbuf_q & ~sel_mask;
          mb_d   = mb_q + CW'(1);
        end else if ((kbuf_q == '0) && last_ld_q) begin
          last_ld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (soft_reset) begin
      state_d    = S_IDLE;
      obuf_d     = '0;
      ovld_d     = 1'b0;
      wbuf_d     = '0;
      kbuf_d     = '0;
      last_ld_d  = 1'b0;
      mb_d       = '0;
      rep_tready = 1'b0;
      mem_tready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      obuf_q    <= '0;
      ovld_q    <= 1'b0;
      wbuf_q    <= '0;
      kbuf_q    <= '0;
      last_ld_q <= 1'b0;
      mb_q      <= '0;
    end else begin
      state_q   <= state_d;
      obuf_q    <= obuf_d;
      ovld_q    <= ovld_d;
      wbuf_q    <= wbuf_d;
      kbuf_q    <= kbuf_d;
      last_ld_q <= last_ld_d;
      mb_q      <= mb_d;
    end
  end

  assign str_txd_tvalid = ovld_q;
  assign str_txd_tdata  = obuf_q;
  assign busy           = (state_q != S_IDLE) || ovld_q;
  assign mem_bytes      = mb_q;

endmodule
